fi_campaign_ctrl: RTL

Sequencer for fault-injection campaigns on the 72-bit ECC codeword path. It accepts codewords from a valid/ready source and routes each one through the combinational `fault_injector`. Every `cfg_period`-th word gets the programmed injection mode on `fi_control`. Each result is registered toward the ECC decoder under test, tagged with whether a fault was injected, and the number of injections is counted.

---
 rtl/fi_pkg.sv | 30 +++
 rtl/fi_period_counter.sv | 42 ++++
 rtl/fi_campaign_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fi_pkg.sv
// Shared types and constants for the fault-injection campaign controller.
// Used by fi_campaign_ctrl (FI_MODE_ROTATE_EN selects rotating injection modes).
package fi_pkg;

  typedef enum logic [1:0] {
    FI_NONE   = 2'b00,
    FI_SINGLE = 2'b01,
    FI_DOUBLE = 2'b10,
    FI_RANDOM = 2'b11
  } fi_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fi_state_e;

  localparam int FI_DATA_W = 72;

  // Rotation order SINGLE -> DOUBLE -> RANDOM -> SINGLE; NONE never enters the cycle.
  function automatic fi_mode_e fi_next_rot(input fi_mode_e m);
    case (m)
      FI_SINGLE: fi_next_rot = FI_DOUBLE;
      FI_DOUBLE: fi_next_rot = FI_RANDOM;
      default:   fi_next_rot = FI_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/fi_period_counter.sv
// Phase counter for the injection period: hit marks the last phase of each period.
// A period of zero never hits.
module fi_period_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  input  logic             en,
  output logic             hit
);

  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_d;

  assign hit = (period_q != '0) && (phase_q == period_q - CNT_W'(1));

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = hit ? '0 : phase_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      phase_q  <= '0;
    end else begin
      if (load) begin
        period_q <= load_val;
      end
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/fi_campaign_ctrl.sv
// Fault-injection campaign sequencer feeding the combinational injector and registering results.
// Optional build macro FI_MODE_ROTATE_EN: rotate injection modes 01->10->11 on each injection word.
module fi_campaign_ctrl
  import fi_pkg::*;
#(
  parameter int DATA_W = FI_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] fi_in,
  output logic [1:0]        fi_control,
  input  logic [DATA_W-1:0] fi_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_injected,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  inj_cnt
);

  fi_state_e         state_q, state_d;
  fi_mode_e          mode_q;
  fi_mode_e          rot_q;
  fi_mode_e          eff_mode;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  word_cnt_d;
  logic [CNT_W-1:0]  inj_cnt_q;
  logic              out_valid_q;
  logic              out_injected_q;
  logic [DATA_W-1:0] out_data_q;
  logic              launch;
  logic              accept;
  logic              xfer;
  logic              hit;
  logic              inj_word;
  logic              inj_active;

  assign launch = (state_q == IDLE) && start && !stop;
  // stop wins over acceptance so the aborting cycle never moves a word.
  assign accept = (state_q == RUN) && !stop && (!out_valid_q || out_ready);
  assign xfer   = in_valid && accept;

  fi_period_counter #(
    .CNT_W(CNT_W)
  ) u_period (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (launch),
    .load_val (cfg_period),
    .clear    (launch),
    .en       (xfer),
    .hit      (hit)
  );

`ifdef FI_MODE_ROTATE_EN
  assign eff_mode = (mode_q == FI_NONE) ? FI_NONE : rot_q;
`else
  assign eff_mode = mode_q;
`endif

  assign inj_word   = xfer && hit;
  assign inj_active = inj_word && (eff_mode != FI_NONE);
  assign word_cnt_d = word_cnt_q + CNT_W'(1);

  assign in_ready     = accept;
  assign fi_in        = in_data;
  assign fi_control   = inj_word ? eff_mode : FI_NONE;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_injected = out_injected_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign inj_cnt      = inj_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (xfer && (count_q != '0) && (word_cnt_d == count_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_q || out_ready) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mode_q         <= FI_NONE;
      rot_q          <= FI_SINGLE;
      count_q        <= '0;
      word_cnt_q     <= '0;
      inj_cnt_q      <= '0;
      out_valid_q    <= 1'b0;
      out_injected_q <= 1'b0;
      out_data_q     <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        mode_q     <= fi_mode_e'(cfg_mode);
        rot_q      <= FI_SINGLE;
        count_q    <= cfg_count;
        word_cnt_q <= '0;
        inj_cnt_q  <= '0;
      end else begin
        if (xfer) word_cnt_q <= word_cnt_d;
        if (inj_active && (inj_cnt_q != '1)) inj_cnt_q <= inj_cnt_q + CNT_W'(1);
        if (inj_active) rot_q <= fi_next_rot(rot_q);
      end
      // A new transfer overrides the sink's clear in the same cycle.
      if (xfer) begin
        out_valid_q    <= 1'b1;
        out_data_q     <= fi_out;
        out_injected_q <= inj_active;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
